// File: rtl/switch_debouncer_if.sv
// Switch conditioner bus: raw switch levels in, debounced levels and edge strobes out.
//   sw_in   : raw asynchronous switch inputs (driven by master)
//   sw_out  : debounced levels, bit 2..0 -> LUT inputs A,B,C
//   sw_rise : 1-cycle strobe on a 0->1 change of sw_out
//   sw_fall : 1-cycle strobe on a 1->0 change of sw_out
interface switch_debouncer_if #(
  parameter int unsigned WIDTH = 3
);
  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] sw_out;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;

  modport master (output sw_in, input sw_out, input sw_rise, input sw_fall);
  modport slave  (input sw_in, output sw_out, output sw_rise, output sw_fall);
endinterface

// File: rtl/switch_debouncer.sv
// Multi-channel switch conditioner: per channel an N-flop synchroniser, a
// STABLE/PENDING qualifier FSM and a saturating-by-construction counter.
// A new synchronised level must persist DEBOUNCE_CYCLES consecutive cycles
// before it is committed to sw_out.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset, clears every flop
//   bus   : switch_debouncer_if.slave (sw_in in; sw_out, sw_rise, sw_fall out)
// Build option: define SWITCH_DEBOUNCER_EDGE_EN to generate sw_rise/sw_fall;
// otherwise both are tied to zero. sw_out is identical in both builds.
module switch_debouncer #(
  parameter int unsigned WIDTH           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  switch_debouncer_if.slave bus
);

  localparam int unsigned CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam bit          NO_FILTER = (DEBOUNCE_CYCLES == 1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  logic [WIDTH-1:0] out_vec;
  logic [WIDTH-1:0] out_nxt_vec;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   syn;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   out_q, out_d;

    // Synchroniser chain; bit 0 is the metastability-exposed flop.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sw_in[g]};
    end

    assign syn = sync_q[SYNC_STAGES-1];

    // Qualifier state register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_STABLE;
        cnt_q   <= '0;
        out_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        out_q   <= out_d;
      end
    end

    // Next-state: cnt counts consecutive cycles of syn disagreeing with out_q;
    // commit happens on the DEBOUNCE_CYCLES-th such cycle, so cnt never wraps.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      unique case (state_q)
        ST_STABLE: begin
          if (syn != out_q) begin
            if (NO_FILTER) begin
              out_d = syn;
            end else begin
              state_d = ST_PENDING;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_PENDING: begin
          if (syn == out_q) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q >= CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
            out_d   = syn;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
      endcase
    end

    assign out_vec[g]     = out_q;
    assign out_nxt_vec[g] = out_d;
  end

  assign bus.sw_out = out_vec;

`ifdef SWITCH_DEBOUNCER_EDGE_EN
  logic [WIDTH-1:0] rise_d, fall_d;
  logic [WIDTH-1:0] rise_q, fall_q;

  // Strobes are registered alongside sw_out so they coincide with the change.
  always_comb begin
    rise_d = out_nxt_vec & ~out_vec;
    fall_d = ~out_nxt_vec & out_vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign bus.sw_rise = rise_q;
  assign bus.sw_fall = fall_q;
`else
  logic unused_nxt;
  assign unused_nxt  = ^out_nxt_vec;
  assign bus.sw_rise = '0;
  assign bus.sw_fall = '0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer (WIDTH=3, DEBOUNCE_CYCLES=4, SYNC_STAGES=2).
// A run-length model predicts sw_out/sw_rise/sw_fall every cycle; directed
// literal checks pin the latency and glitch-rejection scenarios.
module tb_switch_debouncer;
  localparam int unsigned WIDTH = 3;
  localparam int unsigned DEB   = 4;
  localparam int unsigned SYNC  = 2;
`ifdef SWITCH_DEBOUNCER_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  switch_debouncer_if #(.WIDTH(WIDTH)) bus_if ();

  switch_debouncer #(
    .WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the input is seen SYNC edges late; a channel flips once the delayed
  // input has disagreed with the held output for DEB edges in a row.
  logic [WIDTH-1:0] pipe [SYNC];
  int               run  [WIDTH];
  logic [WIDTH-1:0] m_out, m_rise, m_fall;

  always @(posedge clk or negedge rst_n) begin : model
    logic [WIDTH-1:0] n_out, n_rise, n_fall;
    if (!rst_n) begin
      for (int k = 0; k < SYNC; k++) pipe[k] <= '0;
      for (int c = 0; c < WIDTH; c++) run[c] <= 0;
      m_out  <= '0;
      m_rise <= '0;
      m_fall <= '0;
    end else begin
      n_out  = m_out;
      n_rise = '0;
      n_fall = '0;
      for (int c = 0; c < WIDTH; c++) begin
        if (pipe[SYNC-1][c] != m_out[c]) begin
          if (run[c] + 1 == DEB) begin
            n_out[c] = pipe[SYNC-1][c];
            if (EDGE_EN) begin
              n_rise[c] = pipe[SYNC-1][c];
              n_fall[c] = ~pipe[SYNC-1][c];
            end
            run[c] <= 0;
          end else begin
            run[c] <= run[c] + 1;
          end
        end else begin
          run[c] <= 0;
        end
      end
      for (int k = SYNC - 1; k > 0; k--) pipe[k] <= pipe[k-1];
      pipe[0] <= bus_if.sw_in;
      m_out  <= n_out;
      m_rise <= n_rise;
      m_fall <= n_fall;
    end
  end

  // Cycle-by-cycle comparison against the model on the falling edge.
  int rise_cnt0 = 0;
  always @(negedge clk) begin
    checks++;
    if (bus_if.sw_out !== m_out ||
        bus_if.sw_rise !== m_rise || bus_if.sw_fall !== m_fall) begin
      failures++;
      $display("FAIL model_cmp t=%0t got out=%b rise=%b fall=%b exp out=%b rise=%b fall=%b",
               $time, bus_if.sw_out, bus_if.sw_rise, bus_if.sw_fall, m_out, m_rise, m_fall);
    end
    if (bus_if.sw_rise[0] === 1'b1) rise_cnt0++;
  end

  task automatic chk(input string name, input logic [WIDTH-1:0] got,
                     input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] edge_exp(input logic [WIDTH-1:0] v);
    return EDGE_EN ? v : '0;
  endfunction

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] v;
    int               r0;
    rst_n        = 1'b0;
    bus_if.sw_in = 3'b111;

    // Outputs held at zero throughout reset even with inputs high.
    repeat (3) begin
      edges(1);
      chk("rst_out", bus_if.sw_out, 3'b000);
      chk("rst_rise", bus_if.sw_rise, 3'b000);
      chk("rst_fall", bus_if.sw_fall, 3'b000);
    end
    @(negedge clk);
    rst_n        = 1'b1;
    bus_if.sw_in = 3'b000;
    repeat (10) @(negedge clk);

    // Clean change appears exactly 6 edges after the first sampling edge.
    bus_if.sw_in = 3'b101;
    edges(5);
    chk("lat_before", bus_if.sw_out, 3'b000);
    edges(1);
    chk("lat_out", bus_if.sw_out, 3'b101);
    chk("lat_rise", bus_if.sw_rise, edge_exp(3'b101));
    edges(1);
    chk("lat_rise_width", bus_if.sw_rise, 3'b000);
    @(negedge clk);
    bus_if.sw_in = 3'b000;
    edges(6);
    chk("fall_out", bus_if.sw_out, 3'b000);
    chk("fall_strobe", bus_if.sw_fall, edge_exp(3'b101));
    repeat (5) @(negedge clk);

    // A 3-cycle pulse is shorter than the qualification window.
    bus_if.sw_in = 3'b010;
    repeat (3) @(negedge clk);
    bus_if.sw_in = 3'b000;
    repeat (15) @(negedge clk);
    chk("glitch_out", bus_if.sw_out, 3'b000);

    // Bounce on channel 0, then settle high: exactly one rise.
    r0 = rise_cnt0;
    for (int i = 0; i < 10; i++) begin
      bus_if.sw_in[0] = ~bus_if.sw_in[0];
      @(negedge clk);
    end
    bus_if.sw_in = 3'b001;
    edges(5);
    chk("bounce_before", bus_if.sw_out, 3'b000);
    edges(1);
    chk("bounce_out", bus_if.sw_out, 3'b001);
    chk("bounce_rise", bus_if.sw_rise, edge_exp(3'b001));
    repeat (5) @(negedge clk);
    chk("bounce_one_rise", 3'(rise_cnt0 - r0), EDGE_EN ? 3'd1 : 3'd0);

    // Reset while channels are pending; release with input held.
    bus_if.sw_in = 3'b010;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    edges(1);
    chk("midrst_out", bus_if.sw_out, 3'b000);
    chk("midrst_fall", bus_if.sw_fall, 3'b000);
    edges(1);
    chk("midrst_rise", bus_if.sw_rise, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    edges(5);
    chk("rel_before", bus_if.sw_out, 3'b000);
    edges(1);
    chk("rel_out", bus_if.sw_out, 3'b010);
    chk("rel_rise", bus_if.sw_rise, edge_exp(3'b010));
    chk("rel_fall", bus_if.sw_fall, 3'b000);
    repeat (5) @(negedge clk);

    // Sweep all {A,B,C} combinations.
    prev = 3'b010;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      bus_if.sw_in = v;
      edges(6);
      chk("sweep_out", bus_if.sw_out, v);
      chk("sweep_rise", bus_if.sw_rise, edge_exp(v & ~prev));
      chk("sweep_fall", bus_if.sw_fall, edge_exp(~v & prev));
      prev = v;
      repeat (14) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
